edge_generator: RTL and testbench
=================================

Name: edge_generator

Overview:
- Edge/pulse transmitter: the producing end of the level/edge interface that `edge_detector` consumes.
- Accepts a pulse-train request over a valid/ready handshake and drives a level output `a_o` with programmed high and low widths and a repeat count.
- Emits single-cycle `rising_edge_o` / `falling_edge_o` strobes coincident with each transition of `a_o`.
- Sits beside the APB peripheral as a programmable stimulus/strobe source; its `a_o` feeds edge-detect logic downstream.

Parameters:
- CNT_W, 8, width of the high/low length fields (cycles).
- REP_W, 4, width of the repeat field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request ready; high only in IDLE.
- high_len_i  input  CNT_W  high-phase width in cycles; 0 is treated as 1.
- low_len_i  input  CNT_W  low-phase width in cycles; 0 is treated as 1.
- repeat_i  input  REP_W  number of pulses minus 1.
- abort_i  input  1  terminate the current train.
- a_o  output  1  generated level.
- rising_edge_o  output  1  one-cycle strobe when `a_o` goes 0->1.
- falling_edge_o  output  1  one-cycle strobe when `a_o` goes 1->0.
- busy_o  output  1  state != IDLE.
- done_o  output  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset: clk is the single clock; reset is synchronous, active-high.
  - While reset is sampled high: state=IDLE; `a_o`, `rising_edge_o`, `falling_edge_o`, `busy_o`, `done_o` all 0; counters cleared.
  - `req_ready_o`=1, since it is decoded from state.
  - Reset mid-train: `a_o` drops on the next edge with no `falling_edge_o` strobe and no `done_o`.
- FSM states: IDLE, HIGH, LOW.
- Outputs are registered except `req_ready_o` and `busy_o`, which are state decodes.
- Accept: at a posedge with state=IDLE, `req_valid_i`=1, `abort_i`=0.
  - Latch `max(high_len_i,1)`, `max(low_len_i,1)` and `repeat_i` (pulses = `repeat_i`+1).
  - Go to HIGH; `a_o`=1 and `rising_edge_o`=1 in the following cycle (latency 0 cycles after the accepting edge).
- HIGH: `a_o`=1 for exactly HL cycles, then LOW with `falling_edge_o`=1 in the first LOW cycle.
- LOW: `a_o`=0 for exactly LL cycles.
  - At the end of LOW, if pulses remain: go to HIGH with `rising_edge_o`=1 and decrement the pulse counter.
  - Otherwise: go to IDLE with `done_o`=1 in the first IDLE cycle.
- Back-to-back trains: a new request is accepted in the IDLE cycle at the earliest. The inter-train low gap is therefore LL+1 cycles.
- Abort: `abort_i` sampled in HIGH or LOW goes to IDLE on that edge.
  - Next cycle: `a_o`=0 and `done_o`=1.
  - `falling_edge_o`=1 only if `a_o` was 1.
  - Abort in IDLE is ignored.
  - Abort together with `req_valid_i` in IDLE: abort wins, the request is not accepted, and `req_ready_o` stays 1.
- Inputs are ignored while busy; latched values are unaffected.
- Counters: length down-counter loads width-1 and moves phase at 0. Maximum width is 2^CNT_W-1 cycles with no wrap.
- Invariants:
  - `rising_edge_o`/`falling_edge_o` are never both high.
  - Each strobe always equals the change of `a_o` relative to the previous cycle, except for the reset case above.

Decomposition:
- Package `edge_gen_pkg`:
  - `typedef enum logic [1:0] {IDLE, HIGH, LOW} edge_gen_state_t`
  - default localparams CNT_W=8, REP_W=4
- Sub-module `len_counter`: loadable down-counter with parameter W, ports `load`, `load_val`, `en`, `zero`. Instantiated once for phase length; the repeat count uses a plain register.

Test Plan:
- Reset: hold reset 2 cycles with `req_valid_i`=1 -> `a_o`=0, `done_o`=0, `req_ready_o`=1, no accept.
- Basic train: accept at edge 0 with high=3, low=2, repeat=1 -> `a_o`=1 in cycles 0-2 and 5-7, 0 in cycles 3-4 and 8-9; `rising_edge_o` at 0 and 5; `falling_edge_o` at 3 and 8; `done_o` at cycle 10.
- Zero lengths: high=0, low=0, repeat=0 -> one-cycle high, one-cycle low, `done_o` in the next cycle; `req_ready_o`=0 while busy.
- Abort: high=10, abort in cycle 4 -> `a_o`=0 and `falling_edge_o`=1 in cycle 5, `done_o`=1 in cycle 5. Abort asserted with `req_valid_i` in IDLE -> no accept.
- Back-to-back plus checker: hold `req_valid_i` high for 3 random trains. Feed `a_o` into `edge_detector`; its rising/falling outputs must match the generator strobes delayed by its latency. The inter-train gap must equal LL+1.
- Reset mid-train in HIGH -> `a_o`=0 the next cycle, no `falling_edge_o`, no `done_o`, IDLE.

Source files
------------

// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared types and default widths for the edge/pulse generator.
//   edge_gen_state_t : FSM encoding (IDLE, HIGH, LOW)
//   CNT_W / REP_W    : default widths of the phase-length and repeat fields
package edge_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } edge_gen_state_t;

  localparam int CNT_W = 8;
  localparam int REP_W = 4;

endpackage

// File: rtl/edge_generator_if.sv
// edge_generator_if: pulse-train request channel (valid/ready plus payload).
//   req_valid_i : request valid                      (master -> slave)
//   req_ready_o : generator can accept (IDLE)        (slave  -> master)
//   high_len_i  : high-phase width in cycles, 0 => 1 (master -> slave)
//   low_len_i   : low-phase width in cycles, 0 => 1  (master -> slave)
//   repeat_i    : number of pulses minus 1           (master -> slave)
interface edge_generator_if #(
  parameter int CNT_W = edge_gen_pkg::CNT_W,
  parameter int REP_W = edge_gen_pkg::REP_W
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [CNT_W-1:0] high_len_i;
  logic [CNT_W-1:0] low_len_i;
  logic [REP_W-1:0] repeat_i;

  modport master (
    output req_valid_i, high_len_i, low_len_i, repeat_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i, high_len_i, low_len_i, repeat_i,
    output req_ready_o
  );
endinterface

// File: rtl/edge_generator_len_counter.sv
// len_counter: loadable down-counter used to time one phase of the pulse.
//   clk, reset : clock, synchronous active-high reset (clears count)
//   load       : load load_val (takes priority over en)
//   load_val   : value loaded; a phase of N cycles loads N-1
//   en         : count down by one, saturating at 0
//   zero       : count is 0 (last cycle of the current phase)
module len_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/edge_generator.sv
// edge_generator: drives a level a_o as a programmable pulse train.
//   clk, reset     : clock, synchronous active-high reset
//   req            : request channel (slave); accepted only in IDLE
//   abort_i        : end the current train at the next edge (ignored in IDLE)
//   a_o            : generated level (registered)
//   rising_edge_o  : one-cycle strobe coincident with a_o 0->1 (registered)
//   falling_edge_o : one-cycle strobe coincident with a_o 1->0 (registered)
//   busy_o         : state != IDLE (decode)
//   done_o         : one-cycle pulse in the first IDLE cycle after a train
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int CNT_W = edge_gen_pkg::CNT_W,
  parameter int REP_W = edge_gen_pkg::REP_W
) (
  input  logic             clk,
  input  logic             reset,
  edge_generator_if.slave  req,
  input  logic             abort_i,
  output logic             a_o,
  output logic             rising_edge_o,
  output logic             falling_edge_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  edge_gen_state_t  state;
  logic [CNT_W-1:0] hl_q, ll_q;
  logic [REP_W-1:0] rep_q;       // pulses still to start after the current one
  logic [CNT_W-1:0] hl_in, ll_in;
  logic             accept;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // A zero width would otherwise be meaningless; it behaves as one cycle.
  assign hl_in  = (req.high_len_i == '0) ? ONE : req.high_len_i;
  assign ll_in  = (req.low_len_i  == '0) ? ONE : req.low_len_i;

  // Abort beats a simultaneous request, even in IDLE.
  assign accept = (state == IDLE) && req.req_valid_i && !abort_i;

  assign req.req_ready_o = (state == IDLE);
  assign busy_o          = (state != IDLE);

  // The counter is loaded with width-1 on every phase entry so that it hits
  // zero in the final cycle of that phase.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: if (accept) begin
        cnt_load     = 1'b1;
        cnt_load_val = hl_in - ONE;
      end
      HIGH: if (!abort_i && cnt_zero) begin
        cnt_load     = 1'b1;
        cnt_load_val = ll_q - ONE;
      end
      LOW: if (!abort_i && cnt_zero && rep_q != '0) begin
        cnt_load     = 1'b1;
        cnt_load_val = hl_q - ONE;
      end
      default: ;
    endcase
  end

  len_counter #(.W(CNT_W)) u_len (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (busy_o),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset drops a_o silently: no falling strobe, no done.
      state          <= IDLE;
      a_o            <= 1'b0;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
      done_o         <= 1'b0;
      hl_q           <= '0;
      ll_q           <= '0;
      rep_q          <= '0;
    end else begin
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
      done_o         <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state         <= HIGH;
          a_o           <= 1'b1;
          rising_edge_o <= 1'b1;
          hl_q          <= hl_in;
          ll_q          <= ll_in;
          rep_q         <= req.repeat_i;
        end
        HIGH: if (abort_i) begin
          state          <= IDLE;
          a_o            <= 1'b0;
          falling_edge_o <= 1'b1;
          done_o         <= 1'b1;
        end else if (cnt_zero) begin
          state          <= LOW;
          a_o            <= 1'b0;
          falling_edge_o <= 1'b1;
        end
        LOW: if (abort_i) begin
          // a_o is already low, so there is no edge to report.
          state  <= IDLE;
          done_o <= 1'b1;
        end else if (cnt_zero) begin
          if (rep_q != '0) begin
            state         <= HIGH;
            a_o           <= 1'b1;
            rising_edge_o <= 1'b1;
            rep_q         <= rep_q - REP_W'(1);
          end else begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_generator.sv
// tb_edge_generator: directed plus randomized pulse trains against a
// waveform model; an independent edge-detector model cross-checks strobes.
module tb_edge_generator;

  localparam int CW = 8;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic abort_i = 1'b0;
  logic a_o, rise, fall, busy_o, done_o;

  edge_generator_if #(.CNT_W(CW), .REP_W(RW)) rif ();

  edge_generator #(.CNT_W(CW), .REP_W(RW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (rif.slave),
    .abort_i        (abort_i),
    .a_o            (a_o),
    .rising_edge_o  (rise),
    .falling_edge_o (fall),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream edge-detector model: strobes must equal the change of a_o
  // since the previous cycle, except the cycle right after a reset edge.
  logic prev_a = 1'b0;
  logic rst_q  = 1'b1;
  always @(posedge clk) rst_q <= reset;
  always @(negedge clk) begin
    if (!rst_q) begin
      chk("det_rise", rise, a_o & ~prev_a);
      chk("det_fall", fall, ~a_o & prev_a);
      chk("det_excl", rise & fall, 1'b0);
    end
    prev_a <= a_o;
  end

  // Called just after a negedge sample. Offers one request, then checks
  // every cycle against the ideal waveform: (rep+1) x (HL ones, LL zeros),
  // followed by a done cycle; an abort cuts it short one cycle later.
  task automatic run_train(input int hl, input int ll, input int rep,
                           input int abort_at, input bit hold, input int gap_ll);
    int he, le, n;
    bit lvl[$];
    bit prev, ea, er, ef, ed, eb, last;
    he = (hl == 0) ? 1 : hl;
    le = (ll == 0) ? 1 : ll;
    for (int p = 0; p <= rep; p++) begin
      for (int j = 0; j < he; j++) lvl.push_back(1'b1);
      for (int j = 0; j < le; j++) lvl.push_back(1'b0);
    end
    n = lvl.size();
    rif.req_valid_i = 1'b1;
    rif.high_len_i  = CW'(hl);
    rif.low_len_i   = CW'(ll);
    rif.repeat_i    = RW'(rep);
    chk("acc_ready", rif.req_ready_o, 1'b1);
    @(posedge clk);
    prev = 1'b0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (!hold) rif.req_valid_i = 1'b0;
      abort_i = 1'b0;
      if ((abort_at >= 0 && i == abort_at + 1) || i == n) begin
        ea = 0; er = 0; ef = prev; ed = 1; eb = 0; last = 1;
      end else begin
        ea = lvl[i]; er = ea && !prev; ef = !ea && prev; ed = 0; eb = 1; last = 0;
      end
      chk("a_o",   a_o,    ea);
      chk("rise",  rise,   er);
      chk("fall",  fall,   ef);
      chk("done",  done_o, ed);
      chk("busy",  busy_o, eb);
      chk("ready", rif.req_ready_o, !eb);
      if (i == 0 && gap_ll >= 0) chk("gap", cyc - last_fall_t, gap_ll + 1);
      if (fall) last_fall_t = cyc;
      prev = ea;
      if (last) break;
      if (i == abort_at) abort_i = 1'b1;
    end
  endtask

  initial begin
    int hl, ll, rep, prev_ll, he;
    rif.req_valid_i = 1'b1;
    rif.high_len_i  = 8'd3;
    rif.low_len_i   = 8'd2;
    rif.repeat_i    = 4'd0;

    // Reset held two cycles with a pending request.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a",     a_o,    1'b0);
    chk("rst_done",  done_o, 1'b0);
    chk("rst_ready", rif.req_ready_o, 1'b1);
    chk("rst_busy",  busy_o, 1'b0);
    reset = 1'b0;
    rif.req_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy_o, 1'b0);

    run_train(3, 2, 1, -1, 1'b0, -1);      // basic two-pulse train
    run_train(0, 0, 0, -1, 1'b0, -1);      // zero widths act as one
    run_train(10, 2, 0, 4, 1'b0, -1);      // abort in HIGH
    run_train(2, 5, 1, 3, 1'b0, -1);       // abort in LOW: no falling strobe
    run_train(255, 1, 0, -1, 1'b0, -1);    // maximum width, no wrap

    // Abort together with a request in IDLE: not accepted.
    rif.req_valid_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_abort_busy",  busy_o, 1'b0);
    chk("idle_abort_ready", rif.req_ready_o, 1'b1);
    chk("idle_abort_a",     a_o,    1'b0);
    chk("idle_abort_done",  done_o, 1'b0);
    abort_i = 1'b0;
    rif.req_valid_i = 1'b0;
    @(negedge clk);

    // Back-to-back trains with valid held high; gap = LL+1.
    prev_ll = -1;
    for (int k = 0; k < 3; k++) begin
      hl  = $urandom_range(0, 6);
      ll  = $urandom_range(0, 5);
      rep = $urandom_range(0, 3);
      run_train(hl, ll, rep, -1, 1'b1, prev_ll);
      prev_ll = (ll == 0) ? 1 : ll;
    end
    rif.req_valid_i = 1'b0;
    @(negedge clk);

    // Random trains, some aborted during the first high phase.
    for (int k = 0; k < 4; k++) begin
      hl  = $urandom_range(0, 7);
      ll  = $urandom_range(0, 7);
      rep = $urandom_range(0, 2);
      he  = (hl == 0) ? 1 : hl;
      run_train(hl, ll, rep, ($urandom_range(0, 1) == 1) ? $urandom_range(0, he - 1) : -1,
                1'b0, -1);
    end

    // Reset in the middle of a HIGH phase.
    rif.req_valid_i = 1'b1;
    rif.high_len_i  = 8'd10;
    rif.low_len_i   = 8'd3;
    rif.repeat_i    = 4'd2;
    @(posedge clk);
    @(negedge clk);
    rif.req_valid_i = 1'b0;
    chk("mid_pre_a", a_o, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_a",     a_o,    1'b0);
    chk("mid_rst_fall",  fall,   1'b0);
    chk("mid_rst_done",  done_o, 1'b0);
    chk("mid_rst_busy",  busy_o, 1'b0);
    chk("mid_rst_ready", rif.req_ready_o, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_rst_idle", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
